// File: rtl/poly_stream_writer.sv
// Unpacks a two-lane 64-bit coefficient stream into sequential polynomial RAM writes,
// one coefficient per cycle, up to a programmed count; drains surplus beats and flags short packets.
module poly_stream_writer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned LANE_W = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_W:0]         coef_count,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [2*LANE_W-1:0]     s_tdata,
  input  logic [2*LANE_W/8-1:0]   s_tkeep,
  input  logic                    s_tlast,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANE_W-1:0]       mem_wdata,
  output logic                    busy,
  output logic                    done,
  output logic                    err_short
);

  localparam int unsigned KW = LANE_W / 8;
  localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WR_LO, S_WR_HI, S_DRAIN, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_W:0]        cnt_q, cnt_d;
  logic [ADDR_W:0]        tgt_q, tgt_d;
  logic                   err_q, err_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [LANE_W-1:0]      wdata_q, wdata_d;
  logic [2*LANE_W-1:0]    data_q, data_d;
  logic [2*KW-1:0]        keep_q, keep_d;
  logic                   last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Out-of-range counts clamp to a full RAM so the address can never wrap.
          tgt_d   = (coef_count == '0 || coef_count > FULL) ? FULL : coef_count;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (s_tvalid) begin
          data_d  = s_tdata;
          keep_d  = s_tkeep;
          last_d  = s_tlast;
          state_d = S_WR_LO;
        end
      end
      S_WR_LO: begin
        if (keep_q[KW-1:0] == '1) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = data_q[LANE_W-1:0];
          cnt_d   = cnt_q + 1'b1;
        end
        if (cnt_d == tgt_q) state_d = last_q ? S_DONE : S_DRAIN;
        else                state_d = S_WR_HI;
      end
      S_WR_HI: begin
        if (keep_q[2*KW-1:KW] == '1) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_W-1:0];
          wdata_d = data_q[2*LANE_W-1:LANE_W];
          cnt_d   = cnt_q + 1'b1;
        end
        if (cnt_d == tgt_q) begin
          state_d = last_q ? S_DONE : S_DRAIN;
        end else if (last_q) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_DRAIN: begin
        if (s_tvalid && s_tlast) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake and status are pure state decodes, so s_tready never depends on s_tvalid.
  assign s_tready  = (state_q == S_LOAD) || (state_q == S_DRAIN);
  assign busy      = (state_q == S_LOAD) || (state_q == S_WR_LO) ||
                     (state_q == S_WR_HI) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign err_short = err_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule
